// File: rtl/fp_add_sched_if.sv
// Requester-side bundle of the fp_add scheduler: operand handshake in, tagged result strobe out.
// The master modport is the requester side; the slave modport is the scheduler.
interface fp_add_sched_if #(
   parameter int NREQ = 4,
   parameter int W    = 255
);
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic [NREQ-1:0]   rsp_valid;
   logic [W-1:0]      rsp_d;

   modport master (
      output req_valid, req_a, req_b,
      input  req_ready, rsp_valid, rsp_d
   );

   modport slave (
      input  req_valid, req_a, req_b,
      output req_ready, rsp_valid, rsp_d
   );
endinterface

// File: rtl/fp_add_sched.sv
// Round-robin scheduler sharing one pipelined fp_add among NREQ requesters; a requester tag
// travels beside the adder pipeline so each result is strobed back to the requester that issued it.
module fp_add_sched #(
   parameter int NREQ    = 4,
   parameter int LAT_ADD = 2,
   parameter int W       = 255
) (
   input  logic           clk,
   input  logic           rst,
   fp_add_sched_if.slave  s_bus,
   output logic [W-1:0]   o_add_a,
   output logic [W-1:0]   o_add_b,
   input  logic [W-1:0]   i_add_d,
   output logic           o_idle
);
   localparam int IDW = $clog2(NREQ);

   typedef struct packed {
      logic           vld;
      logic [IDW-1:0] id;
   } tag_t;

   logic [IDW-1:0]  r_ptr;
   logic [W-1:0]    r_add_a;
   logic [W-1:0]    r_add_b;
   tag_t            r_tag [LAT_ADD+1];
   logic [NREQ-1:0] r_rsp_valid;
   logic [W-1:0]    r_rsp_d;

   logic [NREQ-1:0] w_grant;
   logic [IDW-1:0]  w_win;
   logic            w_found;
   logic            w_hs;
   logic            w_busy;

   function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int k);
      int s;
      s = (int'(base) + k) % NREQ;
      return IDW'(s);
   endfunction

   // Search starts one past the last winner, so a continuously valid requester waits at most NREQ cycles.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      w_grant = '0;
      w_win   = '0;
      w_found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!w_found && s_bus.req_valid[rr_idx(r_ptr, k)]) begin
            w_found = 1'b1;
            w_win   = rr_idx(r_ptr, k);
         end
      end
      if (w_found && !rst) w_grant[w_win] = 1'b1;
   end

   assign w_hs = w_found & ~rst;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr       <= IDW'(NREQ - 1);
         r_add_a     <= '0;
         r_add_b     <= '0;
         r_rsp_valid <= '0;
         r_rsp_d     <= '0;
         // NOTE: the tag pipe is an array but it is reset: its valid bits are what discard in-flight ops.
         for (int i = 0; i <= LAT_ADD; i++) r_tag[i] <= '0;
      end else begin
         if (w_hs) begin
            r_add_a <= s_bus.req_a[int'(w_win)*W +: W];
            r_add_b <= s_bus.req_b[int'(w_win)*W +: W];
            r_ptr   <= w_win;
         end
         r_tag[0] <= '{vld: w_hs, id: w_win};
         for (int i = 1; i <= LAT_ADD; i++) r_tag[i] <= r_tag[i-1];

         // Last tag stage lines up with the adder output produced from the issue register.
         if (r_tag[LAT_ADD].vld) begin
            r_rsp_d     <= i_add_d;
            r_rsp_valid <= NREQ'(1) << r_tag[LAT_ADD].id;
         end else begin
            r_rsp_valid <= '0;
         end
      end
   end

   always_comb begin
      w_busy = 1'b0;
      for (int i = 0; i <= LAT_ADD; i++) w_busy = w_busy | r_tag[i].vld;
   end

   assign s_bus.req_ready = w_grant;
   assign s_bus.rsp_valid = r_rsp_valid;
   assign s_bus.rsp_d     = r_rsp_d;
   assign o_add_a         = r_add_a;
   assign o_add_b         = r_add_b;
   assign o_idle          = ~w_busy;
endmodule

// File: tb/tb_fp_add_sched.sv
// Bench for fp_add_sched: a 2-cycle modular adder model, a scoreboard fed at each accept and drained
// at each response, and directed steps for reset, single op, full rotation, wrap, bubble, reset mid-op.
module tb_fp_add_sched;
   localparam int NREQ = 4;
   localparam int LAT  = 2;
   localparam int W    = 255;
   localparam logic [255:0] P = (256'd1 << 255) - 256'd19;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] add_a, add_b, add_d;
   logic [W-1:0] m_p1;
   logic         idle;

   fp_add_sched_if #(.NREQ(NREQ), .W(W)) bus ();

   fp_add_sched #(.NREQ(NREQ), .LAT_ADD(LAT), .W(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .s_bus   (bus),
      .o_add_a (add_a),
      .o_add_b (add_b),
      .i_add_d (add_d),
      .o_idle  (idle)
   );

   always #5 clk = ~clk;

   // Stand-in for fp_add with LATENCY_ADD=2.
   always @(posedge clk) begin
      m_p1  <= W'(({1'b0, add_a} + {1'b0, add_b}) % P);
      add_d <= m_p1;
   end

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   bit mon_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [255:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= P) s = s - P;
      return s[W-1:0];
   endfunction

   function automatic logic [W-1:0] rand_fe();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      v[255] = 1'b0;
      if ($urandom_range(0, 3) == 0) v = v >> $urandom_range(200, 254);
      if (v >= P) v = v - P;
      return v[W-1:0];
   endfunction

   typedef struct {
      logic [1:0]   id;
      logic [W-1:0] d;
      int           due;
   } exp_t;

   exp_t sb[$];
   int   m_ptr = NREQ - 1;

   // Scoreboard monitor: checks grant against a round-robin reference, pushes at accept, pops at response.
   always @(negedge clk) begin
      logic [NREQ-1:0] eg;
      logic [1:0]      idx;
      logic [1:0]      ew;
      bit              found;
      exp_t            e;
      if (mon_en) begin
         if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check("rsp_valid", bus.rsp_valid, 256'(NREQ'(1) << e.id));
            check("rsp_d", bus.rsp_d, e.d);
         end else begin
            check("rsp_quiet", bus.rsp_valid, 0);
         end

         eg = '0;
         ew = '0;
         found = 1'b0;
         if (!rst) begin
            for (int k = 1; k <= NREQ; k++) begin
               idx = 2'((m_ptr + k) % NREQ);
               if (!found && bus.req_valid[idx]) begin
                  found = 1'b1;
                  ew = idx;
                  eg[idx] = 1'b1;
               end
            end
         end
         check("grant", bus.req_ready, eg);

         if (rst) begin
            sb.delete();
            m_ptr = NREQ - 1;
         end else if (found) begin
            sb.push_back('{id: ew,
                           d: mod_add(bus.req_a[int'(ew)*W +: W], bus.req_b[int'(ew)*W +: W]),
                           due: cyc + LAT + 2});
            m_ptr = int'(ew);
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      bus.req_a[i*W +: W] = a;
      bus.req_b[i*W +: W] = b;
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
         next_cycle();
         @(negedge clk);
         if (idle === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      check("idle_wait", 256'(ok), 1);
      next_cycle();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      bus.req_valid = '0;
      bus.req_a = '0;
      bus.req_b = '0;

      // Reset: no grant while rst is high, then cleared outputs and idle.
      next_cycle();
      mon_en = 1'b1;
      bus.req_valid = '1;
      @(negedge clk);
      check("rst_ready", bus.req_ready, 0);
      next_cycle();
      rst = 1'b0;
      bus.req_valid = '0;
      @(negedge clk);
      check("rst_add_a", add_a, 0);
      check("rst_add_b", add_b, 0);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_rsp_d", bus.rsp_d, 0);
      check("rst_idle", idle, 1);

      // All requesters valid: rotation 0,1,2,3 and back-to-back responses 2,4,6,8.
      for (int i = 0; i < NREQ; i++) set_req(i, W'(i + 1), W'(i + 1));
      for (int k = 0; k < 12; k++) begin
         next_cycle();
         bus.req_valid = (k < 8) ? 4'b1111 : 4'b0000;
         @(negedge clk);
         if (k < 8) check("rot_grant", bus.req_ready, 256'(4'b0001 << (k % 4)));
         if (k >= 4) begin
            check("rot_rsp_valid", bus.rsp_valid, 256'(4'b0001 << ((k - 4) % 4)));
            check("rot_rsp_d", bus.rsp_d, 256'(2 * ((k - 4) % 4 + 1)));
         end
      end
      wait_idle();

      // Wrap: last grant to 2, then 1011 valid -> 3,0,1 repeating, never 2.
      next_cycle();
      bus.req_valid = 4'b0100;
      @(negedge clk);
      check("wrap_pre", bus.req_ready, 4'b0100);
      for (int k = 0; k < 6; k++) begin
         next_cycle();
         bus.req_valid = 4'b1011;
         @(negedge clk);
         check("wrap_grant", bus.req_ready,
               (k % 3 == 0) ? 256'(4'b1000) : (k % 3 == 1) ? 256'(4'b0001) : 256'(4'b0010));
      end
      next_cycle();
      bus.req_valid = '0;
      wait_idle();

      // Single op from requester 0: 1+2 returned three cycles after the accept edge.
      set_req(0, W'(1), W'(2));
      next_cycle();
      bus.req_valid = 4'b0001;
      @(negedge clk);
      check("single_ready", bus.req_ready, 4'b0001);
      for (int k = 1; k <= 5; k++) begin
         next_cycle();
         bus.req_valid = '0;
         @(negedge clk);
         if (k == 1) begin
            check("single_add_a", add_a, 1);
            check("single_add_b", add_b, 2);
            check("single_busy", idle, 0);
            check("single_ready_off", bus.req_ready, 0);
         end
         check("single_rsp_valid", bus.rsp_valid, (k == 4) ? 256'(4'b0001) : 256'(0));
         if (k >= 4) begin
            check("single_rsp_d", bus.rsp_d, 3);
            check("single_idle", idle, 1);
         end
      end

      // Bubble: accept, two empty cycles, accept; responses keep the same spacing.
      set_req(0, W'(5), W'(6));
      set_req(1, W'(7), W'(8));
      for (int k = 0; k < 9; k++) begin
         next_cycle();
         bus.req_valid = (k == 0) ? 4'b0001 : (k == 3) ? 4'b0010 : 4'b0000;
         @(negedge clk);
         if (k >= 1) check("bubble_add_a", add_a, (k <= 3) ? 256'(5) : 256'(7));
         check("bubble_rsp_valid", bus.rsp_valid,
               (k == 4) ? 256'(4'b0001) : (k == 7) ? 256'(4'b0010) : 256'(0));
         if (k == 4) check("bubble_rsp_d0", bus.rsp_d, 11);
         if (k == 7) check("bubble_rsp_d1", bus.rsp_d, 15);
      end

      // Reset mid-operation: both accepted ops are discarded.
      set_req(0, W'(9), W'(10));
      set_req(1, W'(11), W'(12));
      for (int k = 0; k < 9; k++) begin
         next_cycle();
         bus.req_valid = (k == 0) ? 4'b0001 : (k == 1) ? 4'b0010 : (k == 2) ? 4'b1111 : 4'b0000;
         rst = (k == 2);
         @(negedge clk);
         if (k == 2) check("midrst_ready", bus.req_ready, 0);
         if (k >= 3) begin
            check("midrst_rsp_valid", bus.rsp_valid, 0);
            check("midrst_add_a", add_a, 0);
            check("midrst_add_b", add_b, 0);
            check("midrst_idle", idle, 1);
         end
      end

      // Random traffic; the monitor checks every grant and response.
      for (int k = 0; k < 10000; k++) begin
         next_cycle();
         bus.req_valid = 4'($urandom_range(0, 15));
         for (int i = 0; i < NREQ; i++) set_req(i, rand_fe(), rand_fe());
      end
      next_cycle();
      bus.req_valid = '0;
      wait_idle();
      check("sb_empty", 256'(sb.size()), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
